// File: rtl/rf_writeback_pkg.sv
// Shared types and widths for the register-file writeback path.
package rf_writeback_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rf_writeback_fifo.sv
// Small FIFO buffering long-latency results; the head is visible combinationally
// so it can be popped in the same cycle it is arbitrated.
module wb_fifo
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_req_t                  din,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               push_ok;
  logic               pop_ok;

  // Guards keep the pointers sane even if a caller misbehaves; no bypass path.
  assign push_ok = push && (count_reg != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port owner: arbitrates ALU results against buffered
// long-latency results, tracks outstanding destinations and registers the write.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ch0_vld,
  output logic                  ch0_ready,
  input  logic [REG_ADDR_W-1:0] ch0_rd,
  input  logic [XLEN-1:0]       ch0_data,
  input  logic                  ch1_vld,
  output logic                  ch1_ready,
  input  logic [REG_ADDR_W-1:0] ch1_rd,
  input  logic [XLEN-1:0]       ch1_data,
  input  logic                  issue_vld,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  RFWr,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t               fifo_din;
  wb_req_t               head;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [STV_W-1:0]      starve_reg;
  logic                  force_head;
  logic                  ch0_win;
  logic                  push;
  logic                  pop;
  logic                  rfwr_reg;
  logic [REG_ADDR_W-1:0] a3_reg;
  logic [XLEN-1:0]       wd_reg;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // A head that has lost STARVE_LIMIT times in a row takes the slot by refusing ch0.
  assign force_head = !fifo_empty && (starve_reg == STV_W'(STARVE_LIMIT));

  assign ch0_ready = !rst && !force_head;
  assign ch1_ready = !rst && !fifo_full;

  // An rd=0 ALU result is consumed but yields the slot to the FIFO.
  assign ch0_win = ch0_vld && ch0_ready && (ch0_rd != '0);
  assign push    = ch1_vld && ch1_ready;
  assign pop     = !rst && !ch0_win && !fifo_empty;

  assign fifo_din.rd   = ch1_rd;
  assign fifo_din.data = ch1_data;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg <= '0;
    end else if (pop || fifo_empty) begin
      starve_reg <= '0;
    end else if (starve_reg != STV_W'(STARVE_LIMIT)) begin
      starve_reg <= starve_reg + STV_W'(1);
    end
  end

  // A3/WD only move on a real write so the RF sees stable values otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rfwr_reg <= 1'b0;
      a3_reg   <= '0;
      wd_reg   <= '0;
    end else begin
      rfwr_reg <= 1'b0;
      if (ch0_win) begin
        rfwr_reg <= 1'b1;
        a3_reg   <= ch0_rd;
        wd_reg   <= ch0_data;
      end else if (pop && (head.rd != '0)) begin
        rfwr_reg <= 1'b1;
        a3_reg   <= head.rd;
        wd_reg   <= head.data;
      end
    end
  end

  assign RFWr = rfwr_reg;
  assign A3   = a3_reg;
  assign WD   = wd_reg;

  assign busy[0] = 1'b0;

  // Issue-set beats pop-clear when both hit the same register.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
    logic busy_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        busy_reg <= 1'b0;
      end else if (issue_vld && (issue_rd == REG_ADDR_W'(gi))) begin
        busy_reg <= 1'b1;
      end else if (pop && (head.rd == REG_ADDR_W'(gi))) begin
        busy_reg <= 1'b0;
      end
    end
    assign busy[gi] = busy_reg;
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_rf_writeback;
  import rf_writeback_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        ch0_vld, ch0_ready, ch1_vld, ch1_ready, issue_vld, RFWr;
  logic [4:0]  ch0_rd, ch1_rd, issue_rd, A3;
  logic [31:0] ch0_data, ch1_data, WD, busy;

  rf_writeback #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch0_vld   (ch0_vld),
    .ch0_ready (ch0_ready),
    .ch0_rd    (ch0_rd),
    .ch0_data  (ch0_data),
    .ch1_vld   (ch1_vld),
    .ch1_ready (ch1_ready),
    .ch1_rd    (ch1_rd),
    .ch1_data  (ch1_data),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .busy      (busy),
    .RFWr      (RFWr),
    .A3        (A3),
    .WD        (WD)
  );

  typedef struct {
    bit          we;
    logic [4:0]  a3;
    logic [31:0] wd;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  wb_req_t     m_fifo[$];
  int          m_starve = 0;
  logic [31:0] m_busy = '0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // One cycle of stimulus: drive, check readies/busy, advance the model, queue the expected write state.
  task automatic step(input bit r, input bit c0v, input logic [4:0] c0rd, input logic [31:0] c0d,
                      input bit c1v, input logic [4:0] c1rd, input logic [31:0] c1d,
                      input bit iv, input logic [4:0] ird, output bit acc1);
    exp_t    e;
    wb_req_t h;
    bit      e0r, e1r, c0win, pop, push;
    int      sz;
    @(negedge clk);
    rst = r; ch0_vld = c0v; ch0_rd = c0rd; ch0_data = c0d;
    ch1_vld = c1v; ch1_rd = c1rd; ch1_data = c1d; issue_vld = iv; issue_rd = ird;
    #1;
    sz  = m_fifo.size();
    e0r = !r && !(sz > 0 && m_starve == LIMIT);
    e1r = !r && (sz < DEPTH);
    check(busy == m_busy, "busy", busy, m_busy);
    check(ch0_ready == e0r, "ch0_ready", ch0_ready, e0r);
    check(ch1_ready == e1r, "ch1_ready", ch1_ready, e1r);
    if (!r && iv && ird != 0) check(busy[ird] == 1'b0, "issue_to_busy_reg", busy[ird], 0);
    acc1 = c1v && e1r;
    e.we = 0;
    if (r) begin
      m_fifo.delete();
      m_starve = 0; m_busy = '0; m_a3 = '0; m_wd = '0;
    end else begin
      c0win = c0v && e0r && (c0rd != 0);
      pop   = !c0win && sz > 0;
      push  = c1v && e1r;
      if (c0win) begin
        e.we = 1; m_a3 = c0rd; m_wd = c0d;
      end else if (pop) begin
        h = m_fifo.pop_front();
        if (h.rd != 0) begin
          e.we = 1; m_a3 = h.rd; m_wd = h.data;
        end
        m_busy[h.rd] = 1'b0;
      end
      if (iv && ird != 0) m_busy[ird] = 1'b1;
      m_busy[0] = 1'b0;
      if (pop || sz == 0) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (push) begin
        h.rd = c1rd; h.data = c1d;
        m_fifo.push_back(h);
      end
    end
    e.a3 = m_a3; e.wd = m_wd; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit r);
    bit a;
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  // Monitor: compare the registered write port after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.cyc == cyc, "edge_align", cyc, e.cyc);
        check(RFWr == e.we, "RFWr", RFWr, e.we);
        check(A3 == e.a3, "A3", A3, e.a3);
        check(WD == e.wd, "WD", WD, e.wd);
      end
    end
  end

  initial begin
    bit acc;
    int k;
    logic [4:0] rd_a, rd_b;
    rst = 1; ch0_vld = 0; ch0_rd = 0; ch0_data = 0; ch1_vld = 0; ch1_rd = 0; ch1_data = 0;
    issue_vld = 0; issue_rd = 0;

    repeat (2) idle(1);
    idle(0);

    // Reset mid-operation with two queued entries.
    step(0, 0, 0, 0, 0, 0, 0, 1, 20, acc);
    step(0, 0, 0, 0, 0, 0, 0, 1, 21, acc);
    step(0, 1, 3, 32'h1, 1, 20, 32'hAAAA0020, 0, 0, acc);
    step(0, 1, 3, 32'h2, 1, 21, 32'hAAAA0021, 0, 0, acc);
    idle(1);
    repeat (3) idle(0);

    // ALU write to x5.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
    idle(0);

    // Long-latency x7 with scoreboard clear.
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, acc);
    idle(0);
    step(0, 0, 0, 0, 1, 7, 32'h12345678, 0, 0, acc);
    repeat (2) idle(0);

    // Starvation: ch0 hammers x3 while x9 waits in the FIFO.
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, acc);
    step(0, 1, 3, $urandom, 1, 9, 32'h99999999, 0, 0, acc);
    for (int i = 0; i < 8; i++) step(0, 1, 3, $urandom, 0, 0, 0, 0, 0, acc);
    idle(0);

    // FIFO full with ch1_vld held; order preserved through forced pops.
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      step(0, 1, 3, $urandom, 1, 5'(10 + k), 32'hC0DE0000 + k, 0, 0, acc);
      if (acc) k++;
    end
    check(k == 4, "full_scenario_pushes", k, 4);
    repeat (4) idle(0);

    // rd=0 traffic: x4 queued, then ch0 rd=0 hands the slot to it.
    step(0, 1, 3, 32'h33, 1, 4, 32'h44444444, 0, 0, acc);
    step(0, 1, 0, 32'h0BAD0BAD, 1, 0, 32'hFFFFFFFF, 0, 0, acc);
    repeat (3) idle(0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, c0v, c1v, iv;
      r    = ($urandom_range(0, 199) == 0);
      c0v  = ($urandom_range(0, 9) < 6);
      c1v  = ($urandom_range(0, 9) < 5);
      rd_a = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd_b = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      k    = $urandom_range(1, 31);
      iv   = ($urandom_range(0, 9) < 3) && !m_busy[k];
      step(r, c0v, rd_a, $urandom, c1v, rd_b, $urandom, iv, 5'(k), acc);
    end
    repeat (6) idle(0);

    @(posedge clk);
    #2;
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Single owner of the register-file write port (RFWr, A3, WD).
- Merges two result producers:
  - ch0: single-cycle ALU results; highest priority.
  - ch1: long-latency multiply/divide and load results; buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding long-latency destinations; issue logic uses it for hazard stalls.
- Write output is registered: one cycle from acceptance to the RF write edge.

Parameters:
- FIFO_DEPTH, 2, entries in the ch1 buffer; power of two, ≥2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose to ch0 before it is forced through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ch0_vld  in  1  ALU result valid.
- ch0_ready  out  1  ALU result accepted this cycle.
- ch0_rd  in  5  ALU destination register.
- ch0_data  in  32  ALU result.
- ch1_vld  in  1  long-latency result valid.
- ch1_ready  out  1  FIFO can accept a ch1 result.
- ch1_rd  in  5  long-latency destination register.
- ch1_data  in  32  long-latency result.
- issue_vld  in  1  long-latency op issued this cycle.
- issue_rd  in  5  destination of the issued op.
- busy  out  32  busy[r]=1: a long-latency write to r is outstanding.
- RFWr  out  1  register-file write enable (registered).
- A3  out  5  register-file write address (registered).
- WD  out  32  register-file write data (registered).

Behaviour:
- Reset (clk edge with rst=1):
  - FIFO count, rd/wr pointers, starve counter = 0.
  - RFWr=0, A3=0, WD=0, busy=0.
  - While rst=1: ch0_ready=0, ch1_ready=0. rst overrides all other inputs, including mid-operation; FIFO contents are discarded.
- ch1_ready = !rst && count<FIFO_DEPTH. Depends on registered count only; no push-through when full.
- ch1 push when ch1_vld && ch1_ready: {ch1_rd, ch1_data} written at wr_ptr; wr_ptr wraps modulo FIFO_DEPTH.
  - ch1_rd=0 is pushed like any other entry. It is discarded on pop (no RFWr) and does not touch busy.
- force = (count>0) && (starve==STARVE_LIMIT).
- ch0_ready = !rst && !force.
- Per-cycle write-slot arbitration:
  - ch0_vld && ch0_ready && ch0_rd!=0 → ch0 wins; FIFO head is not popped.
  - ch0_vld && ch0_ready && ch0_rd=0 → ch0 is accepted but discarded; the slot passes to the FIFO.
  - Otherwise, if count>0 → pop head.
  - Otherwise → no write.
- Write register, next edge:
  - RFWr=1 with A3/WD of the winner. rd=0 winners never assert RFWr.
  - RFWr=0 when there is no winner. A3 and WD then hold their previous values.
- Starve counter:
  - Cleared on pop or when count=0.
  - Else incremented when the head loses, saturating at STARVE_LIMIT.
- Simultaneous push and pop: count unchanged. A pop from an empty FIFO never occurs, so a same-cycle push cannot bypass the FIFO.
- Busy scoreboard:
  - issue_vld && issue_rd!=0 sets busy[issue_rd].
  - Popping a FIFO entry with rd=r clears busy[r].
  - Set and clear of the same r in one cycle: set wins.
  - ch0 writes never alter busy.
  - busy[0] is always 0.
- Issuing to a register whose busy bit is already 1 is illegal. The issue logic prevents it; the bench asserts it never occurs.
- Ordering: ch1 entries reach the RF in push order. ch0 and ch1 results carry no relative ordering guarantee; busy-based stalls provide it.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - Typedef wb_req_t {rd[4:0], data[31:0]}.
- One sub-module: wb_fifo. Parameterised depth; push/pop/count/head; synchronous reset; no bypass.
- Arbitration, starve counter, scoreboard and output register stay in rf_writeback.

Test Plan:
- Reset mid-operation: 2 entries queued, rst pulsed 1 cycle → count=0, busy=0, RFWr=0; the queued rd values are never written.
- ch0_vld, rd=5, data=0xDEADBEEF, FIFO empty → RFWr=1, A3=5, WD=0xDEADBEEF one cycle later; ch0_ready=1 throughout.
- issue rd=7; later ch1 push rd=7, data=0x12345678, ch0 idle → write rd=7 one cycle after push, and busy[7] clears on the same edge.
- ch0 valid every cycle with rd=3 while ch1 holds rd=9 → after 4 losing cycles ch0_ready=0 for one cycle, rd=9 is written, starve resets, and ch0 resumes.
- FIFO full (2 entries) with ch1_vld held → ch1_ready=0 and no push. After one pop, ch1_ready=1 the next cycle. Push order is preserved at A3.
- ch0 rd=0 and ch1 push rd=0 with data 0xFFFFFFFF → RFWr stays 0, busy unchanged, the FIFO drains normally, and a queued rd=4 is written in the same cycle as the ch0 rd=0 discard.
